// File: rtl/regfile_sb_pkg.sv
// Shared constants for the scoreboarded register file: default sizes,
// register-count derivation and the hardwired-zero register index.
package regfile_sb_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int ADDR_W_DEF = 4;
    localparam int REG_ZERO   = 0;

    function automatic int nregs(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_sb_sb_bits.sv
// Busy-bit scoreboard: one flop per register, set and clear vectors,
// set wins over clear; bit 0 never becomes busy.
module sb_bits
    import regfile_sb_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] set,
    input  logic [N-1:0] clr,
    output logic [N-1:0] q
);

    logic [N-1:0] keep_mask;

    // Every register except the hardwired-zero one may be tracked.
    always_comb begin
        keep_mask           = '1;
        keep_mask[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= ((q & ~clr) | set) & keep_mask;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with write-first bypass, register 0
// tied to zero, and a busy scoreboard that stalls decode on RAW/WAW hazards.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [WIDTH-1:0]         wd,
    input  logic [ADDR_W-1:0]        ra1,
    input  logic [ADDR_W-1:0]        ra2,
    output logic [WIDTH-1:0]         rd1,
    output logic [WIDTH-1:0]         rd2,
    input  logic                     use1,
    input  logic                     use2,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_rd,
    output logic                     stall,
    output logic [nregs(ADDR_W)-1:0] busy
);

    localparam int NREGS = nregs(ADDR_W);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [WIDTH-1:0] regs [NREGS];
    logic             wr_en;
    logic             iss_ok;
    logic             raw;
    logic             waw;
    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] pend_vec;

    assign wr_en = we && (wa != ZERO_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wa] <= wd;
        end
    end

    // Write-first bypass; forced to zero while reset is held.
    always_comb begin
        rd1 = regs[ra1];
        rd2 = regs[ra2];
        if (wr_en && wa == ra1) rd1 = wd;
        if (wr_en && wa == ra2) rd2 = wd;
        if (reset || ra1 == ZERO_ADDR) rd1 = '0;
        if (reset || ra2 == ZERO_ADDR) rd2 = '0;
    end

    // Issue handshake: decode holds iss_valid/iss_rd while stall is high;
    // the destination is claimed only in a cycle with iss_valid && !stall.
    // A retiring register is no longer pending in its retire cycle.
    always_comb begin
        clr_vec  = wr_en ? (NREGS'(1) << wa) : '0;
        pend_vec = busy & ~clr_vec;
        raw      = (use1 && pend_vec[ra1]) || (use2 && pend_vec[ra2]);
        waw      = iss_valid && pend_vec[iss_rd];
        stall    = raw || waw;
        iss_ok   = iss_valid && !stall && (iss_rd != ZERO_ADDR);
        set_vec  = iss_ok ? (NREGS'(1) << iss_rd) : '0;
    end

    sb_bits #(
        .N(NREGS)
    ) u_sb_bits (
        .clk  (clk),
        .reset(reset),
        .set  (set_vec),
        .clr  (clr_vec),
        .q    (busy)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: bypass, zero register, scoreboard hazards,
// set-wins issue/retire and asynchronous reset.
module tb_regfile_sb;

    logic        clk;
    logic        reset;
    logic        we;
    logic [3:0]  wa;
    logic [7:0]  wd;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [7:0]  rd1;
    logic [7:0]  rd2;
    logic        use1;
    logic        use2;
    logic        iss_valid;
    logic [3:0]  iss_rd;
    logic        stall;
    logic [15:0] busy;

    int total;
    int bad;

    regfile_sb #(.WIDTH(8), .ADDR_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .use1     (use1),
        .use2     (use2),
        .iss_valid(iss_valid),
        .iss_rd   (iss_rd),
        .stall    (stall),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock, then drive the next cycle's inputs 1 ns later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        we = 1'b0; wa = '0; wd = '0;
        ra1 = '0; ra2 = '0;
        use1 = 1'b0; use2 = 1'b0;
        iss_valid = 1'b0; iss_rd = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // 1: reset state
        ra1 = 4'd3; ra2 = 4'd0;
        #1;
        check("rst_rd1", 32'(rd1), 32'h0);
        check("rst_rd2", 32'(rd2), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);

        // 2: write-first bypass, then stored value
        next_cycle();
        we = 1'b1; wa = 4'd5; wd = 8'hA5; ra1 = 4'd5;
        #1;
        check("byp_rd1", 32'(rd1), 32'hA5);
        next_cycle();
        we = 1'b0; ra2 = 4'd5;
        #1;
        check("stored_rd1", 32'(rd1), 32'hA5);
        check("stored_rd2", 32'(rd2), 32'hA5);
        check("nonbusy_retire_busy", 32'(busy), 32'h0);

        // 3: register 0 discards writes and issues
        next_cycle();
        we = 1'b1; wa = 4'd0; wd = 8'hFF; ra1 = 4'd0; ra2 = 4'd0;
        #1;
        check("r0_byp_rd1", 32'(rd1), 32'h0);
        next_cycle();
        we = 1'b0; iss_valid = 1'b1; iss_rd = 4'd0;
        #1;
        check("r0_rd1", 32'(rd1), 32'h0);
        check("r0_iss_stall", 32'(stall), 32'h0);
        next_cycle();
        iss_valid = 1'b0;
        #1;
        check("r0_iss_busy", 32'(busy), 32'h0);

        // plain array read on port 2
        we = 1'b1; wa = 4'd3; wd = 8'h3C;
        next_cycle();
        we = 1'b0; ra2 = 4'd3;
        #1;
        check("arr_rd2", 32'(rd2), 32'h3C);

        // 4: issue 7, RAW stall, retire clears stall in the same cycle
        next_cycle();
        iss_valid = 1'b1; iss_rd = 4'd7;
        #1;
        check("iss7_stall", 32'(stall), 32'h0);
        next_cycle();
        iss_valid = 1'b0; use1 = 1'b1; ra1 = 4'd7;
        #1;
        check("raw7_stall", 32'(stall), 32'h1);
        check("raw7_busy", 32'(busy), 32'h0080);
        next_cycle();
        we = 1'b1; wa = 4'd7; wd = 8'h5A;
        #1;
        check("ret7_stall", 32'(stall), 32'h0);
        check("ret7_rd1", 32'(rd1), 32'h5A);
        next_cycle();
        we = 1'b0;
        #1;
        check("ret7_busy", 32'(busy), 32'h0);
        check("ret7_rd1_arr", 32'(rd1), 32'h5A);
        use1 = 1'b0;

        // 5: WAW stall, then same-cycle issue and retire (set wins)
        iss_valid = 1'b1; iss_rd = 4'd4;
        next_cycle();
        #1;
        check("iss4_busy", 32'(busy), 32'h0010);
        check("waw4_stall", 32'(stall), 32'h1);
        next_cycle();
        #1;
        check("waw4_busy_hold", 32'(busy), 32'h0010);
        we = 1'b1; wa = 4'd4; wd = 8'h44;
        #1;
        check("waw4_clr_stall", 32'(stall), 32'h0);
        next_cycle();
        we = 1'b0; iss_valid = 1'b0; ra1 = 4'd4;
        #1;
        check("setwins_busy", 32'(busy), 32'h0010);
        check("setwins_rd1", 32'(rd1), 32'h44);
        use2 = 1'b1; ra2 = 4'd4;
        #1;
        check("raw4_port2_stall", 32'(stall), 32'h1);
        use2 = 1'b0;
        #1;
        check("nouse_stall", 32'(stall), 32'h0);

        // 6: build busy=00F0, then asynchronous reset mid-cycle
        iss_valid = 1'b1; iss_rd = 4'd5;
        next_cycle();
        iss_rd = 4'd6;
        next_cycle();
        iss_rd = 4'd7;
        next_cycle();
        iss_valid = 1'b0; use1 = 1'b1; ra1 = 4'd5;
        #1;
        check("pre_rst_busy", 32'(busy), 32'h00F0);
        check("pre_rst_rd1", 32'(rd1), 32'hA5);
        check("pre_rst_stall", 32'(stall), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("async_busy", 32'(busy), 32'h0);
        check("async_rd1", 32'(rd1), 32'h0);
        check("async_stall", 32'(stall), 32'h0);
        next_cycle();
        reset = 1'b0;
        next_cycle();
        check("post_rst_rd1", 32'(rd1), 32'h0);
        check("post_rst_busy", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
